// File: rtl/serial_addsub_pkg.sv
// Shared types and mode encodings for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Two's-complement overflow from the operand sign bits and the result sign bit.
    function automatic logic ovf_rule(input logic mode, input logic a_msb,
                                      input logic b_msb, input logic s_msb);
        if (mode == MODE_SUB) begin
            return (a_msb != b_msb) && (s_msb != a_msb);
        end
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_addsub_cell.sv
// One-bit full adder/subtractor: carry out in add mode, borrow out in subtract mode.
module serial_addsub_cell
    import serial_addsub_pkg::*;
(
    input  logic ai,
    input  logic bi,
    input  logic ci,
    input  logic a_ns,
    output logic sum,
    output logic co
);

    logic prop;

    assign prop = ai ^ bi;
    assign sum  = prop ^ ci;

    always_comb begin
        co = 1'b0;
        if (a_ns == MODE_SUB) begin
            co = (~ai & bi) | (ci & ~prop);
        end else begin
            co = (ai & bi) | (ci & prop);
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract of two WIDTH-bit operands, LSB first, one bit per clock.
// Optional zero flag output z enabled by defining SERIAL_ADDSUB_ZFLAG_EN.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a_ns,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    output logic             ovf,
    output logic             z
`else
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-2:0] res_q;
    logic             mode_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    logic             nz_q;
`endif

    logic             sum_d;
    logic             carry_d;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;
    logic             last_c;

    serial_addsub_cell u_cell (
        .ai   (a_sh_q[0]),
        .bi   (b_sh_q[0]),
        .ci   (carry_q),
        .a_ns (mode_q),
        .sum  (sum_d),
        .co   (carry_d)
    );

    // Bits collected so far live in res_q; the new sum bit enters from the MSB side.
    assign res_d  = {sum_d, res_q};
    assign last_c = (cnt_q == CNT_W'(WIDTH - 1));
    // On the last bit the cell inputs are the operand sign bits and sum_d is the result sign.
    assign ovf_d  = ovf_rule(mode_q, a_sh_q[0], b_sh_q[0], sum_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            mode_q  <= MODE_ADD;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
            nz_q    <= 1'b0;
            z       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        mode_q  <= a_ns;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= RUN;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
                        nz_q    <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    carry_q <= carry_d;
                    res_q   <= res_d[WIDTH-1:1];
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    cnt_q   <= cnt_q + CNT_W'(1);
`ifdef SERIAL_ADDSUB_ZFLAG_EN
                    nz_q    <= nz_q | sum_d;
`endif
                    if (last_c) begin
                        s       <= res_d;
                        cout    <= carry_d;
                        ovf     <= ovf_d;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
                        z       <= ~(nz_q | sum_d);
`endif
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed, table-driven bench for serial_addsub (WIDTH=8), with hand-written
// sequences for start held high, mid-run reset and result hold behaviour.
module tb_serial_addsub;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             a_ns;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
`ifdef SERIAL_ADDSUB_ZFLAG_EN
    logic             z;
`endif

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_ns  (a_ns),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
`ifdef SERIAL_ADDSUB_ZFLAG_EN
        .ovf   (ovf),
        .z     (z)
`else
        .ovf   (ovf)
`endif
    );

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vm;
        logic [7:0] es;
        logic       ec;
        logic       eo;
        string      nm;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Last result the bench expects the DUT to be holding.
    logic [7:0] prev_s = '0;
    logic       prev_c = 1'b0;
    logic       prev_o = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output int cyc, output logic held_ok, output logic busy_ok);
        cyc     = 0;
        held_ok = 1'b1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (s !== prev_s || cout !== prev_c || ovf !== prev_o) held_ok = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string nm, input logic [7:0] es, input logic ec,
                                input logic eo);
        check({nm, " s"}, 32'(s), 32'(es));
        check({nm, " cout"}, 32'(cout), 32'(ec));
        check({nm, " ovf"}, 32'(ovf), 32'(eo));
`ifdef SERIAL_ADDSUB_ZFLAG_EN
        check({nm, " z"}, 32'(z), 32'(es == 8'h00));
`endif
        prev_s = es;
        prev_c = ec;
        prev_o = eo;
    endtask

    // One full operation; operand inputs are scrambled right after acceptance.
    task automatic run_op(input vec_t v);
        int   cyc;
        logic held_ok;
        logic busy_ok;
        @(negedge clk);
        a = v.va; b = v.vb; a_ns = v.vm; start = 1'b1;
        @(posedge clk);
        #1;
        check({v.nm, " busy_at_accept"}, 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0; a = ~v.va; b = ~v.vb; a_ns = ~v.vm;
        wait_done(cyc, held_ok, busy_ok);
        check({v.nm, " latency"}, 32'(cyc), 32'(WIDTH));
        check({v.nm, " hold_during_run"}, 32'(held_ok), 32'd1);
        check({v.nm, " busy_during_run"}, 32'(busy_ok), 32'd1);
        check({v.nm, " busy_at_done"}, 32'(busy), 32'd0);
        check_result(v.nm, v.es, v.ec, v.eo);
        @(posedge clk);
        #1;
        check({v.nm, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        vec_t vecs[9];
        vec_t vz;
        int   cyc;
        logic held_ok;
        logic busy_ok;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "add_35_4a"};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01"};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_01"};
        vecs[3] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0, "sub_10_20"};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1, "sub_80_01"};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "add_80_80"};
        vecs[6] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_00_01"};
        vecs[7] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b1, "sub_7f_ff"};
        vecs[8] = '{8'hC3, 8'h3C, 1'b0, 8'hFF, 1'b0, 1'b0, "add_c3_3c"};

        rst = 1'b1; start = 1'b0; a_ns = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset s", 32'(s), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
`ifdef SERIAL_ADDSUB_ZFLAG_EN
        check("reset z", 32'(z), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i]);
        end

        // start held high through RUN and DONE; second op accepted only from IDLE.
        @(negedge clk);
        a = 8'h05; b = 8'h03; a_ns = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        check("hold_start busy_at_accept", 32'(busy), 32'd1);
        @(negedge clk);
        a = 8'h01; b = 8'h01;
        wait_done(cyc, held_ok, busy_ok);
        check("hold_start first latency", 32'(cyc), 32'(WIDTH));
        check_result("hold_start first", 8'h08, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("hold_start done_edge done", 32'(done), 32'd0);
        check("hold_start done_edge busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("hold_start reaccept busy", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, held_ok, busy_ok);
        check("hold_start second latency", 32'(cyc), 32'(WIDTH));
        check("hold_start second hold", 32'(held_ok), 32'd1);
        check_result("hold_start second", 8'h02, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("hold_start second done_pulse", 32'(done), 32'd0);

        // Reset sampled at E4 of a run discards everything, including held outputs.
        @(negedge clk);
        a = 8'h33; b = 8'h11; a_ns = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_rst busy", 32'(busy), 32'd0);
        check("midrun_rst done", 32'(done), 32'd0);
        check("midrun_rst s", 32'(s), 32'd0);
        check("midrun_rst cout", 32'(cout), 32'd0);
        check("midrun_rst ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_s = '0; prev_c = 1'b0; prev_o = 1'b0;
        @(posedge clk);
        #1;
        check("after_rst idle busy", 32'(busy), 32'd0);

        vz = '{8'h0A, 8'h0A, 1'b1, 8'h00, 1'b0, 1'b0, "post_rst sub_0a_0a"};
        run_op(vz);
        vz = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_rst add_01_01"};
        run_op(vz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
